// File: rtl/spi_slave_if.sv
// Bundles the SPI pins and the host-side byte handshake of the SPI slave.
// The slave modport is the DUT view. The master modport is the view of
// whatever drives the pins and the host side.
interface spi_slave_if;
   logic [7:0] data_s;
   logic [7:0] spcon;
   logic       sck;
   logic       ssn;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic [7:0] data_r_s;
   logic       data_finish_s;
   logic       data_req_s;

   modport slave (
      input  data_s, spcon, sck, ssn, mosi,
      output miso, miso_oe, data_r_s, data_finish_s, data_req_s
   );

   modport master (
      output data_s, spcon, sck, ssn, mosi,
      input  miso, miso_oe, data_r_s, data_finish_s, data_req_s
   );
endinterface

// File: rtl/spi_slave.sv
// 8-bit SPI slave that oversamples sck/ssn/mosi in the clk domain.
// It supports all four CPOL/CPHA modes and back-to-back bytes under one ssn.
// Received bytes are handed over with a one-cycle strobe. The next transmit
// byte is requested with a one-cycle strobe whenever it is captured.
module spi_slave #(
   parameter int SYNC_STAGES = 2
) (
   input logic       clk,
   input logic       rst_n,
   spi_slave_if.slave bus
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sck_sync, ssn_sync, mosi_sync;
   logic       sck_s, ssn_s, mosi_s;
   logic       sck_prev, sel_prev;
   logic       cpol_l, cpha_l;
   logic [7:0] tx_sr, rx_sr, data_r;
   logic [3:0] edge_cnt;
   logic       miso_r, finish_r, req_r;
   logic       sel, sel_rise, sck_edge, leading, trailing, sample_edge, byte_done;
   logic       unused_spcon;

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign ssn_s  = ssn_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   assign sel         = ~ssn_s & bus.spcon[6];
   assign sel_rise    = sel & ~sel_prev;
   assign sck_edge    = sck_s ^ sck_prev;
   assign leading     = sck_edge & (sck_s != cpol_l);
   assign trailing    = sck_edge & (sck_s == cpol_l);
   assign sample_edge = cpha_l ? trailing : leading;
   assign byte_done   = (state == ACTIVE) && sample_edge &&
                        (edge_cnt == (cpha_l ? 4'd15 : 4'd14));
   assign unused_spcon = ^{bus.spcon[7], bus.spcon[5:3], bus.spcon[0]};

   // Synchronizer chains for the asynchronous pins, reset to the idle bus levels
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sck_sync  <= '0;
         ssn_sync  <= '1;
         mosi_sync <= '0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
         ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], bus.ssn};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: enter on select rising, leave as soon as select drops
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (sel_rise) state_nxt = ACTIVE;
         ACTIVE:  if (!sel)     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shifters, edge counter and handshake strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sck_prev <= 1'b0;
         sel_prev <= 1'b0;
         cpol_l   <= 1'b0;
         cpha_l   <= 1'b0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         data_r   <= '0;
         edge_cnt <= '0;
         miso_r   <= 1'b0;
         finish_r <= 1'b0;
         req_r    <= 1'b0;
      end else begin
         sck_prev <= sck_s;
         sel_prev <= sel;
         finish_r <= byte_done;
         req_r    <= 1'b0;
         if (byte_done) begin
            data_r <= {rx_sr[6:0], mosi_s};
         end
         case (state)
            IDLE: begin
               miso_r   <= 1'b0;
               edge_cnt <= '0;
               if (sel_rise) begin
                  cpol_l <= bus.spcon[2];
                  cpha_l <= bus.spcon[1];
                  tx_sr  <= bus.data_s;
                  req_r  <= 1'b1;
                  rx_sr  <= '0;
                  if (!bus.spcon[1]) begin
                     miso_r <= bus.data_s[7];
                  end
               end
            end
            ACTIVE: begin
               if (!sel) begin
                  miso_r   <= 1'b0;
                  edge_cnt <= '0;
               end else if (sck_edge) begin
                  edge_cnt <= edge_cnt + 4'd1;
                  if (sample_edge) begin
                     rx_sr <= {rx_sr[6:0], mosi_s};
                  end
                  if (trailing && edge_cnt == 4'd15) begin
                     tx_sr <= bus.data_s;
                     req_r <= 1'b1;
                     if (!cpha_l) begin
                        miso_r <= bus.data_s[7];
                     end
                  end else if (!cpha_l && trailing) begin
                     miso_r <= tx_sr[6];
                     tx_sr  <= {tx_sr[6:0], 1'b0};
                  end else if (cpha_l && leading) begin
                     miso_r <= tx_sr[7];
                     tx_sr  <= {tx_sr[6:0], 1'b0};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs: the pad is driven only while a selection is active
   always_comb begin
      bus.miso_oe       = (state == ACTIVE);
      bus.miso          = (state == ACTIVE) & miso_r;
      bus.data_r_s      = data_r;
      bus.data_finish_s = finish_r;
      bus.data_req_s    = req_r;
   end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave. It acts as the SPI master on the pins and as
// the host on the byte handshake, with hand-computed expected values.
module tb_spi_slave;

   logic clk;
   logic rst_n;
   spi_slave_if bus();

   spi_slave #(.SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int compCount = 0;
   int failCount = 0;
   int finishCount = 0;
   int reqCount = 0;
   int oeCycles = 0;
   int wideCount = 0;
   logic [7:0] finishLog[$];
   logic prevFinish = 1'b0;
   logic prevReq = 1'b0;
   logic curCpol = 1'b0;
   logic curCpha = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor: counts strobes, logs received bytes, flags strobes wider than one cycle
   always @(negedge clk) begin
      if (bus.data_finish_s) begin
         finishLog.push_back(bus.data_r_s);
         finishCount++;
      end
      if (bus.data_req_s) reqCount++;
      if (bus.miso_oe) oeCycles++;
      if ((bus.data_finish_s && prevFinish) || (bus.data_req_s && prevReq)) wideCount++;
      prevFinish = bus.data_finish_s;
      prevReq = bus.data_req_s;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic setMode(input logic cpol, input logic cpha, input logic en);
      curCpol = cpol;
      curCpha = cpha;
      bus.spcon = {1'b0, en, 3'b000, cpol, cpha, 1'b0};
      bus.sck = cpol;
      waitClk(8);
   endtask

   // Master side: shifts nbits MSB first with an sck half-period of 8 clk
   task automatic applyStimulus(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < nbits; i++) begin
         if (!curCpha) begin
            bus.mosi = tx[7-i];
            waitClk(8);
            bus.sck = ~curCpol;
            acc = {acc[6:0], bus.miso};
            waitClk(8);
            bus.sck = curCpol;
         end else begin
            bus.sck = ~curCpol;
            bus.mosi = tx[7-i];
            waitClk(8);
            bus.sck = curCpol;
            acc = {acc[6:0], bus.miso};
            waitClk(8);
         end
      end
      rx = acc;
   endtask

   initial begin
      logic [7:0] rx, rx2;
      int fB, rB, oB;

      rst_n = 1'b0;
      bus.sck = 1'b0;
      bus.ssn = 1'b1;
      bus.mosi = 1'b0;
      bus.spcon = 8'h00;
      bus.data_s = 8'h00;
      waitClk(4);
      checkOutput("reset_miso", bus.miso, 0);
      checkOutput("reset_miso_oe", bus.miso_oe, 0);
      checkOutput("reset_data_r", bus.data_r_s, 0);
      checkOutput("reset_finish", bus.data_finish_s, 0);
      checkOutput("reset_req", bus.data_req_s, 0);
      rst_n = 1'b1;
      waitClk(4);

      $display("[TB] mode 0 single byte");
      setMode(1'b0, 1'b0, 1'b1);
      bus.data_s = 8'h3C;
      fB = finishCount; rB = reqCount;
      bus.ssn = 1'b0;
      waitClk(8);
      checkOutput("m0_req_at_ssn", reqCount - rB, 1);
      applyStimulus(8'hA5, 8, rx);
      waitClk(8);
      checkOutput("m0_data_r", bus.data_r_s, 8'hA5);
      checkOutput("m0_finish_count", finishCount - fB, 1);
      checkOutput("m0_master_rx", rx, 8'h3C);
      checkOutput("m0_req_total", reqCount - rB, 2);
      bus.ssn = 1'b1;
      waitClk(8);

      $display("[TB] mode 3 single byte");
      setMode(1'b1, 1'b1, 1'b1);
      bus.data_s = 8'h7E;
      fB = finishCount;
      checkOutput("m3_oe_before", bus.miso_oe, 0);
      bus.ssn = 1'b0;
      waitClk(8);
      checkOutput("m3_oe_during", bus.miso_oe, 1);
      applyStimulus(8'h81, 8, rx);
      waitClk(8);
      checkOutput("m3_data_r", bus.data_r_s, 8'h81);
      checkOutput("m3_master_rx", rx, 8'h7E);
      checkOutput("m3_finish_count", finishCount - fB, 1);
      bus.ssn = 1'b1;
      waitClk(8);
      checkOutput("m3_oe_after", bus.miso_oe, 0);

      $display("[TB] mode 1 back-to-back");
      setMode(1'b0, 1'b1, 1'b1);
      bus.data_s = 8'h5A;
      fB = finishCount;
      bus.ssn = 1'b0;
      waitClk(8);
      bus.data_s = 8'hCD;
      applyStimulus(8'h12, 8, rx);
      applyStimulus(8'h34, 8, rx2);
      waitClk(8);
      checkOutput("b2b_finish_count", finishCount - fB, 2);
      if (finishCount - fB >= 2) begin
         checkOutput("b2b_first_byte", finishLog[fB], 8'h12);
         checkOutput("b2b_second_byte", finishLog[fB+1], 8'h34);
      end
      checkOutput("b2b_master_rx1", rx, 8'h5A);
      checkOutput("b2b_master_rx2", rx2, 8'hCD);
      bus.ssn = 1'b1;
      waitClk(8);

      $display("[TB] abort after 5 bits");
      setMode(1'b0, 1'b0, 1'b1);
      bus.data_s = 8'hF0;
      fB = finishCount;
      bus.ssn = 1'b0;
      waitClk(8);
      applyStimulus(8'h55, 5, rx);
      bus.ssn = 1'b1;
      waitClk(4);
      checkOutput("abort_oe_low", bus.miso_oe, 0);
      waitClk(8);
      checkOutput("abort_no_finish", finishCount - fB, 0);
      checkOutput("abort_data_kept", bus.data_r_s, 8'h34);
      bus.data_s = 8'h96;
      bus.ssn = 1'b0;
      waitClk(8);
      applyStimulus(8'h69, 8, rx);
      waitClk(8);
      checkOutput("abort_next_data_r", bus.data_r_s, 8'h69);
      checkOutput("abort_next_master_rx", rx, 8'h96);
      bus.ssn = 1'b1;
      waitClk(8);

      $display("[TB] slave disabled");
      setMode(1'b0, 1'b0, 1'b0);
      fB = finishCount; rB = reqCount; oB = oeCycles;
      bus.ssn = 1'b0;
      waitClk(8);
      applyStimulus(8'hC3, 8, rx);
      waitClk(8);
      checkOutput("dis_oe_cycles", oeCycles - oB, 0);
      checkOutput("dis_req_count", reqCount - rB, 0);
      checkOutput("dis_finish_count", finishCount - fB, 0);
      checkOutput("dis_data_kept", bus.data_r_s, 8'h69);
      bus.ssn = 1'b1;
      waitClk(8);

      $display("[TB] reset mid-transfer");
      setMode(1'b0, 1'b0, 1'b1);
      bus.data_s = 8'h11;
      bus.ssn = 1'b0;
      waitClk(8);
      applyStimulus(8'hAA, 3, rx);
      rst_n = 1'b0;
      waitClk(1);
      rst_n = 1'b1;
      checkOutput("rst_miso", bus.miso, 0);
      checkOutput("rst_miso_oe", bus.miso_oe, 0);
      checkOutput("rst_data_r", bus.data_r_s, 0);
      checkOutput("rst_finish", bus.data_finish_s, 0);
      checkOutput("rst_req", bus.data_req_s, 0);
      bus.ssn = 1'b1;
      waitClk(10);
      bus.data_s = 8'h42;
      fB = finishCount;
      bus.ssn = 1'b0;
      waitClk(8);
      applyStimulus(8'hFF, 8, rx);
      waitClk(8);
      checkOutput("rst_fresh_data_r", bus.data_r_s, 8'hFF);
      checkOutput("rst_fresh_master_rx", rx, 8'h42);
      checkOutput("rst_fresh_finish", finishCount - fB, 1);
      bus.ssn = 1'b1;
      waitClk(8);

      checkOutput("strobe_width", wideCount, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
      $finish;
   end

endmodule
